// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// Register file write-port arbiter.
// Shares the single register file write port between the in-order WB stage and the
// multi-cycle mul/div unit (MDU). MDU results are parked in a small FIFO and drained into
// cycles where WB does not write. A per-register scoreboard tracks pending MDU destinations
// for the hazard unit. If the FIFO head waits too long, or the FIFO fills, pipe_hold asks
// the pipeline for WB bubbles.
//
// Ports:
//   clk, rst (async, active-low), cpu_en (low freezes all state)
//   wb_valid/wb_addr/wb_data                       : WB stage write request (highest priority)
//   mdu_issue/mdu_rd                               : MDU op issue, sets scoreboard bit
//   mdu_res_valid/mdu_res_addr/mdu_res_data/_ready : MDU result handshake into the FIFO
//   rs1_address/rs2_address -> rs1_busy/rs2_busy   : hazard queries against the scoreboard
//   is_write_regs/write_address/write_data         : register file write port
//   pipe_hold                                      : registered bubble request
//   proto_err                                      : sticky protocol-violation flag
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REGS_WIDTH   = 5,
  parameter int unsigned REGS_NUM     = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  wb_valid,
  input  logic [REGS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  mdu_issue,
  input  logic [REGS_WIDTH-1:0] mdu_rd,
  input  logic                  mdu_res_valid,
  input  logic [REGS_WIDTH-1:0] mdu_res_addr,
  input  logic [DATA_WIDTH-1:0] mdu_res_data,
  output logic                  mdu_res_ready,
  input  logic [REGS_WIDTH-1:0] rs1_address,
  input  logic [REGS_WIDTH-1:0] rs2_address,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  is_write_regs,
  output logic [REGS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  pipe_hold,
  output logic                  proto_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [AgeW-1:0] LimitAge = AgeW'(STARVE_LIMIT);

  // FIFO storage is not reset; the pointers and count define validity.
  logic [REGS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [REGS_NUM-1:0]   busy_q, busy_d;
  logic [AgeW-1:0]       age_q, age_d;
  logic                  pipe_hold_q, pipe_hold_d;
  logic                  hold_prev_q;
  logic                  proto_err_q, proto_err_d;
  logic [REGS_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] last_data_q;

  logic                  fifo_empty;
  logic                  wb_req;
  logic                  pop;
  logic                  accept;
  logic                  push;
  logic                  issue_set;
  logic [REGS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [REGS_WIDTH-1:0] port_addr;
  logic [DATA_WIDTH-1:0] port_data;
  logic                  issue_err;
  logic                  waw_err;
  logic                  hold_err;

  assign fifo_empty = (count_q == '0);
  assign wb_req     = wb_valid && (wb_addr != '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // A pop does not free a slot for a same-cycle push: ready depends on the current count only.
  assign mdu_res_ready = cpu_en && (count_q < DepthCnt);
  assign accept        = mdu_res_valid && mdu_res_ready;
  // Results to x0 are handshaken but never stored.
  assign push          = accept && (mdu_res_addr != '0);
  assign pop           = cpu_en && !wb_req && !fifo_empty;
  assign issue_set     = cpu_en && mdu_issue && (mdu_rd != '0);

  // Write port: WB first, then the FIFO head.
  assign is_write_regs = cpu_en && (wb_req || !fifo_empty);
  assign port_addr     = wb_req ? wb_addr : head_addr;
  assign port_data     = wb_req ? wb_data : head_data;
  assign write_address = is_write_regs ? port_addr : last_addr_q;
  assign write_data    = is_write_regs ? port_data : last_data_q;

  // Conservative: a clear happening this cycle still reports busy.
  assign rs1_busy = (rs1_address != '0) && busy_q[rs1_address];
  assign rs2_busy = (rs2_address != '0) && busy_q[rs2_address];

  assign pipe_hold = pipe_hold_q;
  assign proto_err = proto_err_q;

  // Re-issuing to a register whose pending result retires this very cycle is legal.
  assign issue_err = issue_set && busy_q[mdu_rd] && !(pop && (head_addr == mdu_rd));
  assign waw_err   = wb_req && busy_q[wb_addr];
  assign hold_err  = wb_valid && hold_prev_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    age_d    = age_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so that a same-cycle set on the same register wins.
    if (pop)       busy_d[head_addr] = 1'b0;
    if (issue_set) busy_d[mdu_rd]    = 1'b1;

    if (pop) begin
      age_d = '0;
    end else if (!fifo_empty && (age_q < LimitAge)) begin
      age_d = age_q + AgeW'(1);
    end

    pipe_hold_d = (age_d >= LimitAge) || (count_d == DepthCnt);
    proto_err_d = proto_err_q || issue_err || waw_err || hold_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      age_q       <= '0;
      pipe_hold_q <= 1'b0;
      hold_prev_q <= 1'b0;
      proto_err_q <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (cpu_en) begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      age_q       <= age_d;
      pipe_hold_q <= pipe_hold_d;
      hold_prev_q <= pipe_hold_q;
      proto_err_q <= proto_err_d;
      if (is_write_regs) begin
        last_addr_q <= port_addr;
        last_data_q <= port_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mdu_res_addr;
      fifo_data_q[wr_ptr_q] <= mdu_res_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_issue;
  logic [4:0]  mdu_rd;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_addr;
  logic [31:0] mdu_res_data;
  logic        mdu_res_ready;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        is_write_regs;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        pipe_hold;
  logic        proto_err;

  int nchk = 0;
  int nfail = 0;

  regfile_write_arbiter u_dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_en        (cpu_en),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .mdu_issue     (mdu_issue),
    .mdu_rd        (mdu_rd),
    .mdu_res_valid (mdu_res_valid),
    .mdu_res_addr  (mdu_res_addr),
    .mdu_res_data  (mdu_res_data),
    .mdu_res_ready (mdu_res_ready),
    .rs1_address   (rs1_address),
    .rs2_address   (rs2_address),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .is_write_regs (is_write_regs),
    .write_address (write_address),
    .write_data    (write_data),
    .pipe_hold     (pipe_hold),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: pending results as a queue, scoreboard as a bit per register.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t      mq[$];
  bit [31:0] mbusy;
  int        mage;
  bit        mhold;
  bit        mhold_prev;
  bit        merr;

  task automatic drive_idle();
    cpu_en        = 1'b1;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    mdu_issue     = 1'b0;
    mdu_rd        = '0;
    mdu_res_valid = 1'b0;
    mdu_res_addr  = '0;
    mdu_res_data  = '0;
  endtask

  // Advance one cycle; returns on the falling edge with idle inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy      = '0;
    mage       = 0;
    mhold      = 1'b0;
    mhold_prev = 1'b0;
    merr       = 1'b0;
  endtask

  task automatic model_step();
    bit   wbq;
    bit   popped;
    int   occ;
    ent_t head;
    ent_t ne;
    if (!cpu_en) return;
    wbq    = wb_valid && (wb_addr != 0);
    occ    = mq.size();
    popped = !wbq && (occ > 0);
    head   = '0;
    if (popped) head = mq[0];
    if (mdu_issue && mdu_rd != 0 && mbusy[mdu_rd] && !(popped && head.a == mdu_rd)) merr = 1'b1;
    if (wbq && mbusy[wb_addr]) merr = 1'b1;
    if (wb_valid && mhold_prev) merr = 1'b1;
    if (popped) begin
      void'(mq.pop_front());
      mbusy[head.a] = 1'b0;
    end
    if (mdu_issue && mdu_rd != 0) mbusy[mdu_rd] = 1'b1;
    if (mdu_res_valid && occ < 2 && mdu_res_addr != 0) begin
      ne.a = mdu_res_addr;
      ne.d = mdu_res_data;
      mq.push_back(ne);
    end
    if (popped) mage = 0;
    else if (occ > 0 && mage < 4) mage = mage + 1;
    mhold_prev = mhold;
    mhold      = (mage >= 4) || (mq.size() == 2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    rs1_address = 5'd5;
    rs2_address = 5'd0;
    #1;
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL rst_we got=%0b want=0", is_write_regs); end
    nchk++; if (mdu_res_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready got=%0b want=1", mdu_res_ready); end
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got=%0b want=0", rs1_busy); end
    nchk++; if (pipe_hold !== 1'b0) begin nfail++; $display("FAIL rst_hold got=%0b want=0", pipe_hold); end
    nchk++; if (proto_err !== 1'b0) begin nfail++; $display("FAIL rst_err got=%0b want=0", proto_err); end
    rst = 1'b1;
    step(); mdu_issue = 1'b1; mdu_rd = 5'd5; #1;
    step();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd5; mdu_res_data = 32'h11;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1;
    nchk++; if (rs1_busy !== 1'b1) begin nfail++; $display("FAIL rstd_busy5 got=%0b want=1", rs1_busy); end
    nchk++; if (write_address !== 5'd9) begin nfail++; $display("FAIL rstd_wbaddr got=%0d want=9", write_address); end
    step(); #1;
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd5 || write_data !== 32'h11) begin
      nfail++; $display("FAIL rstd_head got=%0b/%0d/%h want=1/5/11", is_write_regs, write_address, write_data);
    end
    rst = 1'b0; #1;
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL rstd_we got=%0b want=0", is_write_regs); end
    nchk++; if (mdu_res_ready !== 1'b1) begin nfail++; $display("FAIL rstd_ready got=%0b want=1", mdu_res_ready); end
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL rstd_busy got=%0b want=0", rs1_busy); end
    nchk++; if (pipe_hold !== 1'b0) begin nfail++; $display("FAIL rstd_hold got=%0b want=0", pipe_hold); end
    rst = 1'b1;
    step(); #1;
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL rstd_after_we got=%0b want=0", is_write_regs); end
  endtask

  task automatic test_idle_drain();
    step(); mdu_issue = 1'b1; mdu_rd = 5'd7; rs1_address = 5'd7; #1;
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL drain_pre got=%0b want=0", rs1_busy); end
    step(); mdu_res_valid = 1'b1; mdu_res_addr = 5'd7; mdu_res_data = 32'hDEADBEEF; #1;
    nchk++; if (rs1_busy !== 1'b1) begin nfail++; $display("FAIL drain_busyN got=%0b want=1", rs1_busy); end
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL drain_weN got=%0b want=0", is_write_regs); end
    step(); #1;
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd7 || write_data !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL drain_write got=%0b/%0d/%h want=1/7/deadbeef", is_write_regs, write_address, write_data);
    end
    nchk++; if (rs1_busy !== 1'b1) begin nfail++; $display("FAIL drain_busyN1 got=%0b want=1", rs1_busy); end
    step(); #1;
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL drain_busyN2 got=%0b want=0", rs1_busy); end
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL drain_weN2 got=%0b want=0", is_write_regs); end
  endtask

  task automatic test_priority_starve();
    step(); mdu_issue = 1'b1; mdu_rd = 5'd3; rs1_address = 5'd3; #1;
    step();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd3; mdu_res_data = 32'h5;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
    #1;
    for (int i = 1; i <= 4; i++) begin
      step(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'(i); #1;
      nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd9 || write_data !== 32'(i)) begin
        nfail++; $display("FAIL prio_wb%0d got=%0b/%0d/%h want=1/9/%h", i, is_write_regs, write_address, write_data, i);
      end
      nchk++; if (pipe_hold !== 1'b0) begin nfail++; $display("FAIL prio_hold%0d got=%0b want=0", i, pipe_hold); end
    end
    step(); #1;
    nchk++; if (pipe_hold !== 1'b1) begin nfail++; $display("FAIL starve_hold got=%0b want=1", pipe_hold); end
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd3 || write_data !== 32'h5) begin
      nfail++; $display("FAIL starve_write got=%0b/%0d/%h want=1/3/5", is_write_regs, write_address, write_data);
    end
    step(); #1;
    nchk++; if (pipe_hold !== 1'b0) begin nfail++; $display("FAIL starve_release got=%0b want=0", pipe_hold); end
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL starve_busy got=%0b want=0", rs1_busy); end
    nchk++; if (proto_err !== 1'b0) begin nfail++; $display("FAIL starve_err got=%0b want=0", proto_err); end
    step(); #1;
  endtask

  task automatic test_full_fifo();
    step(); mdu_issue = 1'b1; mdu_rd = 5'd10; #1;
    step(); mdu_issue = 1'b1; mdu_rd = 5'd11; #1;
    step();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd10; mdu_res_data = 32'h100;
    wb_valid = 1'b1; wb_addr = 5'd9; mdu_issue = 1'b1; mdu_rd = 5'd12;
    #1;
    step();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd11; mdu_res_data = 32'h200;
    wb_valid = 1'b1; wb_addr = 5'd9;
    #1;
    nchk++; if (mdu_res_ready !== 1'b1) begin nfail++; $display("FAIL full_ready1 got=%0b want=1", mdu_res_ready); end
    step(); mdu_res_valid = 1'b1; mdu_res_addr = 5'd12; mdu_res_data = 32'h300; #1;
    nchk++; if (mdu_res_ready !== 1'b0) begin nfail++; $display("FAIL full_ready got=%0b want=0", mdu_res_ready); end
    nchk++; if (pipe_hold !== 1'b1) begin nfail++; $display("FAIL full_hold got=%0b want=1", pipe_hold); end
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd10 || write_data !== 32'h100) begin
      nfail++; $display("FAIL full_first got=%0b/%0d/%h want=1/10/100", is_write_regs, write_address, write_data);
    end
    step(); mdu_res_valid = 1'b1; mdu_res_addr = 5'd12; mdu_res_data = 32'h300; #1;
    nchk++; if (mdu_res_ready !== 1'b1) begin nfail++; $display("FAIL full_ready2 got=%0b want=1", mdu_res_ready); end
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd11 || write_data !== 32'h200) begin
      nfail++; $display("FAIL full_second got=%0b/%0d/%h want=1/11/200", is_write_regs, write_address, write_data);
    end
    step(); #1;
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd12 || write_data !== 32'h300) begin
      nfail++; $display("FAIL full_third got=%0b/%0d/%h want=1/12/300", is_write_regs, write_address, write_data);
    end
    step(); #1;
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL full_empty got=%0b want=0", is_write_regs); end
    nchk++; if (proto_err !== 1'b0) begin nfail++; $display("FAIL full_err got=%0b want=0", proto_err); end
  endtask

  task automatic test_set_clear();
    step(); mdu_issue = 1'b1; mdu_rd = 5'd4; rs1_address = 5'd4; #1;
    step(); mdu_res_valid = 1'b1; mdu_res_addr = 5'd4; mdu_res_data = 32'h44; #1;
    step(); mdu_issue = 1'b1; mdu_rd = 5'd4; #1;
    nchk++; if (is_write_regs !== 1'b1 || write_address !== 5'd4 || write_data !== 32'h44) begin
      nfail++; $display("FAIL sc_pop got=%0b/%0d/%h want=1/4/44", is_write_regs, write_address, write_data);
    end
    step(); #1;
    nchk++; if (rs1_busy !== 1'b1) begin nfail++; $display("FAIL sc_setwins got=%0b want=1", rs1_busy); end
    nchk++; if (proto_err !== 1'b0) begin nfail++; $display("FAIL sc_err got=%0b want=0", proto_err); end
    step(); mdu_res_valid = 1'b1; mdu_res_addr = 5'd4; mdu_res_data = 32'h45; #1;
    step(); #1;
    nchk++; if (write_address !== 5'd4 || write_data !== 32'h45) begin
      nfail++; $display("FAIL sc_second got=%0d/%h want=4/45", write_address, write_data);
    end
    step(); #1;
    nchk++; if (rs1_busy !== 1'b0) begin nfail++; $display("FAIL sc_clear got=%0b want=0", rs1_busy); end
  endtask

  task automatic test_proto_x0();
    step();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd0; mdu_res_data = 32'hBAD;
    rs1_address = 5'd0; rs2_address = 5'd6;
    #1;
    nchk++; if (mdu_res_ready !== 1'b1) begin nfail++; $display("FAIL x0_ready got=%0b want=1", mdu_res_ready); end
    step(); #1;
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL x0_nowrite got=%0b want=0", is_write_regs); end
    nchk++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      nfail++; $display("FAIL x0_busy got=%0b%0b want=00", rs1_busy, rs2_busy);
    end
    step(); mdu_issue = 1'b1; mdu_rd = 5'd6; #1;
    step(); mdu_issue = 1'b1; mdu_rd = 5'd6; #1;
    nchk++; if (proto_err !== 1'b0) begin nfail++; $display("FAIL perr_early got=%0b want=0", proto_err); end
    nchk++; if (rs2_busy !== 1'b1) begin nfail++; $display("FAIL perr_busy6 got=%0b want=1", rs2_busy); end
    step(); #1;
    nchk++; if (proto_err !== 1'b1) begin nfail++; $display("FAIL perr_set got=%0b want=1", proto_err); end
    step();
    cpu_en = 1'b0; wb_valid = 1'b1; wb_addr = 5'd2; mdu_res_valid = 1'b1; mdu_res_addr = 5'd2;
    #1;
    nchk++; if (is_write_regs !== 1'b0 || mdu_res_ready !== 1'b0) begin
      nfail++; $display("FAIL dis_port got=%0b/%0b want=0/0", is_write_regs, mdu_res_ready);
    end
    step(); #1;
    nchk++; if (proto_err !== 1'b1) begin nfail++; $display("FAIL perr_sticky got=%0b want=1", proto_err); end
    nchk++; if (is_write_regs !== 1'b0) begin nfail++; $display("FAIL dis_nopush got=%0b want=0", is_write_regs); end
  endtask

  task automatic test_random();
    bit exp_we;
    bit exp_ready;
    bit exp_b1;
    bit exp_b2;
    bit wbq;
    bit obey;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    for (int seg = 0; seg < 4; seg++) begin
      obey = (seg == 0) || (seg == 2);
      for (int c = 0; c < 200; c++) begin
        step();
        cpu_en        = (seg == 0) ? 1'b1 : ($urandom_range(9) != 0);
        wb_valid      = ($urandom_range(9) < ((seg == 3) ? 8 : 4));
        wb_addr       = 5'($urandom_range(7));
        wb_data       = $urandom();
        mdu_issue     = ($urandom_range(3) == 0);
        mdu_rd        = 5'($urandom_range(7));
        mdu_res_valid = ($urandom_range(2) == 0);
        mdu_res_addr  = 5'($urandom_range(7));
        mdu_res_data  = $urandom();
        rs1_address   = 5'($urandom_range(7));
        rs2_address   = 5'($urandom_range(7));
        if (obey) begin
          if (wb_valid && (mbusy[wb_addr] || mhold || mhold_prev)) wb_valid = 1'b0;
          if (mdu_issue && mbusy[mdu_rd]) mdu_issue = 1'b0;
        end
        if (c == 0 || $urandom_range(99) == 0) begin
          rst = 1'b0; #1; rst = 1'b1;
          model_reset();
        end
        #1;
        wbq       = wb_valid && (wb_addr != 0);
        exp_we    = cpu_en && (wbq || mq.size() > 0);
        exp_ready = cpu_en && (mq.size() < 2);
        exp_b1    = (rs1_address != 0) && mbusy[rs1_address];
        exp_b2    = (rs2_address != 0) && mbusy[rs2_address];
        exp_addr  = wbq ? wb_addr : ((mq.size() > 0) ? mq[0].a : 5'd0);
        exp_data  = wbq ? wb_data : ((mq.size() > 0) ? mq[0].d : 32'd0);
        nchk++; if (is_write_regs !== exp_we) begin
          nfail++; $display("FAIL rnd_we seg=%0d cyc=%0d got=%0b want=%0b", seg, c, is_write_regs, exp_we);
        end
        if (exp_we) begin
          nchk++; if (write_address !== exp_addr || write_data !== exp_data) begin
            nfail++; $display("FAIL rnd_port seg=%0d cyc=%0d got=%0d/%h want=%0d/%h", seg, c,
                              write_address, write_data, exp_addr, exp_data);
          end
        end
        nchk++; if (mdu_res_ready !== exp_ready) begin
          nfail++; $display("FAIL rnd_ready seg=%0d cyc=%0d got=%0b want=%0b", seg, c, mdu_res_ready, exp_ready);
        end
        nchk++; if (rs1_busy !== exp_b1 || rs2_busy !== exp_b2) begin
          nfail++; $display("FAIL rnd_busy seg=%0d cyc=%0d got=%0b%0b want=%0b%0b", seg, c,
                            rs1_busy, rs2_busy, exp_b1, exp_b2);
        end
        nchk++; if (pipe_hold !== mhold) begin
          nfail++; $display("FAIL rnd_hold seg=%0d cyc=%0d got=%0b want=%0b", seg, c, pipe_hold, mhold);
        end
        nchk++; if (proto_err !== merr) begin
          nfail++; $display("FAIL rnd_err seg=%0d cyc=%0d got=%0b want=%0b", seg, c, proto_err, merr);
        end
        model_step();
      end
    end
  endtask

  initial begin
    drive_idle();
    rs1_address = '0;
    rs2_address = '0;
    test_reset();
    test_idle_drain();
    test_priority_starve();
    test_full_fifo();
    test_set_clear();
    test_proto_x0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
